// File: rtl/key_sw_input_port.sv
// key_sw_input_port: synchronized, debounced switch/key port with sticky key events.
// Define KEY_SW_DEBOUNCE_EN to enable the per-bit debounce counters.
module key_sw_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_00C0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [2:0]  key,
  input  logic [31:0] addr,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        irq
);

  // keys idle high, switches idle low
  localparam logic [12:0] RST_VAL = {3'b111, 10'b0};

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be 1..65535");
  end
  if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
    $error("BASE_ADDR must be 16-byte aligned");
  end

  logic [12:0] raw;
  logic [12:0] s1;
  logic [12:0] stable;
  logic [12:0] stable_d;
  logic [2:0]  evt;
  logic [2:0]  evt_d;
  logic [2:0]  new_set;
  logic        hit;
  logic        clear;
  logic        unused_addr;

  assign raw         = {key, sw};
  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= RST_VAL;
    end else begin
      s1 <= raw;
    end
  end

`ifdef KEY_SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [12:0]   s2;
  logic [CW-1:0] cnt   [13];
  logic [CW-1:0] cnt_d [13];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2 <= RST_VAL;
    end else begin
      s2 <= s1;
    end
  end

  // accept on the edge that would make the mismatch run DEBOUNCE_CYCLES long
  always_comb begin
    stable_d = stable;
    for (int i = 0; i < 13; i++) begin
      cnt_d[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == LAST) begin
          stable_d[i] = s2[i];
        end else begin
          cnt_d[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 13; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 13; i++) begin
        cnt[i] <= cnt_d[i];
      end
    end
  end
`else
  // stable register acts as the second synchronizer flop
  assign stable_d = s1;
`endif

  assign new_set = stable[12:10] & ~stable_d[12:10];
  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign clear   = rd & hit & (addr[3:2] == 2'd2);
  assign evt_d   = (clear ? 3'b000 : evt) | new_set;
  assign irq     = |evt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable <= RST_VAL;
      evt    <= 3'b000;
    end else begin
      stable <= stable_d;
      evt    <= evt_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      unique case (addr[3:2])
        2'd0: rdata = {22'b0, stable[9:0]};
        2'd1: rdata = {29'b0, ~stable[12:10]};
        2'd2: rdata = {29'b0, evt};
        2'd3: rdata = {31'b0, irq};
      endcase
    end
  end

endmodule
